// File: rtl/lenet_pkg.sv
// ---------------------------------------------------------------------------
// lenet_pkg
// Shared numeric definitions for the LeNet fully-connected stages
// (layer3, layer4, layer5). Data and weights are signed Q8.8. Accumulators
// are wide signed values, and FRAC bits are dropped when an accumulator is
// rescaled back to the data width.
// ---------------------------------------------------------------------------
package lenet_pkg;

    localparam int LENET_DW   = 16;
    localparam int LENET_ACCW = 40;
    localparam int LENET_FRAC = 8;

    // Output activation clamp range: ReLU floor and largest positive Q8.8
    localparam logic [LENET_DW-1:0] Q_SAT_MAX = 16'h7FFF;
    localparam logic [LENET_DW-1:0] Q_SAT_MIN = 16'h0000;

endpackage

// File: rtl/fc_mac_lane.sv
// ---------------------------------------------------------------------------
// fc_mac_lane
// Arithmetic for one output neuron of a fully-connected layer. On each
// accepted term the lane multiplies din by weight at full precision. It then
// either loads the product into the accumulator (first term of a frame) or
// adds the product to it. When out_en is high, the lane rescales the
// accumulator, applies ReLU, saturates the value and registers the result.
//
// Ports
//   clk      : rising-edge clock
//   reset    : synchronous active-high reset, clears acc and dout
//   acc_en   : a term is accepted this cycle
//   acc_load : the accepted term is the first of a frame (load, not add)
//   out_en   : register the rescaled activation into dout
//   din      : signed input activation
//   weight   : signed weight for this lane
//   dout     : registered activation (non-negative, saturated)
// ---------------------------------------------------------------------------
module fc_mac_lane
    import lenet_pkg::*;
#(
    parameter int DW   = LENET_DW,
    parameter int ACCW = LENET_ACCW,
    parameter int FRAC = LENET_FRAC
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 acc_en,
    input  logic                 acc_load,
    input  logic                 out_en,
    input  logic signed [DW-1:0] din,
    input  logic signed [DW-1:0] weight,
    output logic        [DW-1:0] dout
);

    localparam logic signed [ACCW-1:0] SAT_MAX_EXT = ACCW'(Q_SAT_MAX);

    logic signed [2*DW-1:0] product;
    logic signed [ACCW-1:0] product_ext;
    logic signed [ACCW-1:0] acc;
    logic signed [ACCW-1:0] acc_next;
    logic signed [ACCW-1:0] scaled;
    logic        [DW-1:0]   act;

    always_comb begin
        product     = din * weight;
        product_ext = {{(ACCW-2*DW){product[2*DW-1]}}, product};
        acc_next    = acc_load ? product_ext : acc + product_ext;
        scaled      = acc >>> FRAC;
        // ReLU first, then clamp to the largest representable positive value
        if (scaled[ACCW-1]) begin
            act = DW'(Q_SAT_MIN);
        end else if (scaled > SAT_MAX_EXT) begin
            act = DW'(Q_SAT_MAX);
        end else begin
            act = scaled[DW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc  <= '0;
            dout <= '0;
        end else begin
            if (acc_en) begin
                acc <= acc_next;
            end
            if (out_en) begin
                dout <= act;
            end
        end
    end

endmodule

// File: rtl/layer4.sv
// ---------------------------------------------------------------------------
// layer4
// Fully-connected stage with N_IN inputs and N_OUT outputs. Each accepted term
// (din plus one weight per lane) feeds N_OUT parallel MAC lanes. After term
// N_IN-1 is accepted, the FSM spends one cycle in OUT. On that edge every lane
// registers its rescaled, ReLU'd and saturated result into dout, and save
// pulses for one cycle.
//
// Ports
//   clk       : rising-edge clock
//   reset     : synchronous active-high reset
//   ena       : term valid
//   din       : signed Q8.8 input activation
//   weight_in : packed signed weights, lane j in [j*DW +: DW]
//   dout      : packed activations, lane j in [j*DW +: DW]
//   save      : one-cycle pulse when dout has just been updated
//   fc_finish : sticky frame-complete flag, cleared by the next frame's term 0
//   busy      : high while a frame is partially accumulated (ACC, OUT)
// ---------------------------------------------------------------------------
module layer4
    import lenet_pkg::*;
#(
    parameter int N_IN  = 120,
    parameter int N_OUT = 84,
    parameter int DW    = LENET_DW,
    parameter int ACCW  = LENET_ACCW,
    parameter int FRAC  = LENET_FRAC
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ena,
    input  logic signed [DW-1:0]   din,
    input  logic [N_OUT*DW-1:0]    weight_in,
    output logic [N_OUT*DW-1:0]    dout,
    output logic                   save,
    output logic                   fc_finish,
    output logic                   busy
);

    localparam int CW = (N_IN > 1) ? $clog2(N_IN) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACC  = 2'd1;
    localparam logic [1:0] OUT  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]    state;
    logic [CW-1:0] term_cnt;
    logic          accept;
    logic          first_term;
    logic          last_term;
    logic          out_en;

    // Terms presented during OUT are dropped. A term accepted in IDLE or DONE
    // starts a new frame, so the lanes load the product instead of adding it.
    always_comb begin
        accept     = ena && (state != OUT);
        first_term = (state == IDLE) || (state == DONE);
        last_term  = (term_cnt == CW'(N_IN - 1));
        out_en     = (state == OUT);
        busy       = (state == ACC) || (state == OUT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            term_cnt  <= '0;
            save      <= 1'b0;
            fc_finish <= 1'b0;
        end else begin
            save <= 1'b0;
            if (state == OUT) begin
                state     <= DONE;
                save      <= 1'b1;
                fc_finish <= 1'b1;
            end else if (accept) begin
                if (first_term) begin
                    fc_finish <= 1'b0;
                end
                if (last_term) begin
                    state    <= OUT;
                    term_cnt <= '0;
                end else begin
                    state    <= ACC;
                    term_cnt <= term_cnt + 1'b1;
                end
            end
        end
    end

    for (genvar j = 0; j < N_OUT; j++) begin : g_lane
        fc_mac_lane #(
            .DW   (DW),
            .ACCW (ACCW),
            .FRAC (FRAC)
        ) u_lane (
            .clk      (clk),
            .reset    (reset),
            .acc_en   (accept),
            .acc_load (first_term),
            .out_en   (out_en),
            .din      (din),
            .weight   (weight_in[j*DW +: DW]),
            .dout     (dout[j*DW +: DW])
        );
    end

endmodule

// File: doc/layer4.md
LAYER4 -- requirements
Module: layer4

Interface
REQ-001 Parameter N_IN, default 120: input terms per frame (layer3 output count).
REQ-002 Parameter N_OUT, default 84: output neurons / parallel MAC lanes.
REQ-003 Parameter DW, default 16: signed data and weight width, Q8.8 fixed point.
REQ-004 Parameter ACCW, default 40: signed accumulator width per lane.
REQ-005 Parameter FRAC, default 8: fractional bits dropped when rescaling the accumulator to DW.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 ena  input  1  term valid; driven by layer3_buffer layer4_en.
REQ-009 din  input  DW signed  current input activation; driven by layer3_buffer dout.
REQ-010 weight_in  input  N_OUT*DW  packed signed weights for the current term; lane j in bits [j*DW +: DW].
REQ-011 dout  output  N_OUT*DW  packed activations, lane j in bits [j*DW +: DW].
REQ-012 save  output  1  one-cycle pulse; dout is valid and newly updated.
REQ-013 fc_finish  output  1  sticky frame-complete flag.
REQ-014 busy  output  1  high while a frame is partially accumulated.

Function
REQ-015 The FSM SHALL have states IDLE, ACC, OUT and DONE.
REQ-016 A term is accepted on any rising edge where ena=1 and state is IDLE, ACC or DONE; din and weight_in SHALL be sampled on that same edge.
REQ-017 For each accepted term, every lane j SHALL add the full-precision product din*w_j (2*DW bits, sign-extended to ACCW) to acc_j.
REQ-018 The first term of a frame SHALL load acc_j with the product rather than add to the previous value.
REQ-019 A term counter SHALL count 0..N_IN-1; cycles with ena=0 SHALL stall the count and accumulators with no loss of state.
REQ-020 Transitions: IDLE->ACC on the first accepted term; ACC->OUT on acceptance of term N_IN-1; OUT->DONE unconditionally; DONE->ACC on an accepted term, which becomes term 0 of a new frame.
REQ-021 If N_IN=1, acceptance of term 0 SHALL go directly to OUT.
REQ-022 In OUT, each lane SHALL arithmetic-right-shift acc_j by FRAC, apply ReLU (negative->0), saturate to 0x7FFF, and register the result into dout.
REQ-023 save SHALL be high for exactly the one cycle after the OUT edge, with dout updated at that edge; latency from acceptance of the last term to save=1 is 1 cycle.
REQ-024 ena=1 while in OUT SHALL be ignored (term dropped).
REQ-025 fc_finish SHALL set on the same edge as save and clear when the first term of the next frame is accepted.
REQ-026 dout SHALL hold its value until the next OUT.
REQ-027 busy SHALL be 1 in ACC and OUT, and 0 in IDLE and DONE.
REQ-028 Accumulators SHALL wrap modulo 2^ACCW; with the default widths this cannot overflow for N_IN<=256.

Reset
REQ-029 reset=1 SHALL force state IDLE, counter 0, all acc_j 0, dout 0, save 0, fc_finish 0 and busy 0 on the next edge; this takes precedence over ena.
REQ-030 Reset mid-frame SHALL discard partial sums; the next accepted term is term 0.

Structure
REQ-031 DW, ACCW, FRAC and the Q8.8 saturation limits (0x7FFF, 0x0000) SHALL live in shared package lenet_pkg, reused by the layer3 and layer5 stages.
REQ-032 One sub-module fc_mac_lane (multiply, accumulate, rescale, ReLU, saturate), instantiated N_OUT times by generate, SHALL hold the lane arithmetic; layer4 holds the FSM and counter.

Verification
REQ-033 Run 120 consecutive terms with din=0x0100 and all weights 0x0100 -> save pulses 1 cycle after the 120th term, every lane 0x7800 (120.0), fc_finish=1.
REQ-034 Run din=0x0100 with lane0 weight 0xFF00 (-1.0) and lane1 weight 0x0080 (0.5) -> lane0 0x0000 (ReLU), lane1 0x3C00 (60.0).
REQ-035 Run din=0x7FFF with all weights 0x7FFF -> every lane saturates to 0x7FFF.
REQ-036 Drive the REQ-033 stimulus with ena deasserted for 3 cycles after every 10th term -> same results; save occurs 1 cycle after the final term.
REQ-037 Assert reset after term 60, then run a full REQ-033 frame -> 0x7800 with no residue from the aborted frame; save and fc_finish are 0 during reset.
REQ-038 Start a second frame with din=0x0200 immediately after save -> fc_finish clears on its first term; second result is 0x7FFF (240.0 saturated).
